// File: rtl/sha256_padder.sv
// sha256_padder: turns a byte stream into SHA-256 padded 512-bit blocks tagged first/last.
// Optional macro SHA256_PADDER_EMPTY_EN adds in_empty for final beats that carry no byte.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
`ifdef SHA256_PADDER_EMPTY_EN
  input  logic         in_empty,
`endif
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_first,
  output logic         out_last
);

  // state | meaning
  // FILL  | collecting message bytes into the block buffer
  // EMIT  | block presented on out_block, waiting for out_ready
  // EXTRA | building the trailing pad-only block
  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_LEN, PEND_80} pend_t;

  state_t            r_state, w_state_nxt;
  pend_t             r_pend, w_pend_nxt;
  logic [0:63][7:0]  r_buf, w_buf_nxt;
  logic [5:0]        r_idx, w_idx_nxt;
  logic [LEN_W-1:0]  r_bitcnt, w_bitcnt_nxt;
  logic              r_first, w_first_nxt;
  logic              r_last, w_last_nxt;
  logic              r_live;
  logic              w_accept;
  logic              w_empty;
  logic [6:0]        w_p;

`ifdef SHA256_PADDER_EMPTY_EN
  assign w_empty = in_empty & in_last;
`else
  assign w_empty = 1'b0;
`endif

  assign w_accept = in_valid & in_ready;
  // w_p is the number of message bytes in the block once this beat is written.
  assign w_p      = w_empty ? {1'b0, r_idx} : {1'b0, r_idx} + 7'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_pend_nxt   = r_pend;
    w_buf_nxt    = r_buf;
    w_idx_nxt    = r_idx;
    w_bitcnt_nxt = r_bitcnt;
    w_first_nxt  = r_first;
    w_last_nxt   = r_last;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (!w_empty) begin
            w_buf_nxt[r_idx] = in_byte;
            w_bitcnt_nxt     = r_bitcnt + LEN_W'(8);
          end
          if (in_last) begin
            w_state_nxt = EMIT;
            if (w_p == 7'd64) begin
              w_last_nxt = 1'b0;
              w_pend_nxt = PEND_80;
            end else begin
              w_buf_nxt[w_p[5:0]] = 8'h80;
              if (w_p <= 7'd55) begin
                w_buf_nxt[56:63] = 64'(w_bitcnt_nxt);
                w_last_nxt       = 1'b1;
                w_pend_nxt       = PEND_NONE;
              end else begin
                w_last_nxt = 1'b0;
                w_pend_nxt = PEND_LEN;
              end
            end
          end else if (r_idx == 6'd63) begin
            w_state_nxt = EMIT;
            w_last_nxt  = 1'b0;
            w_pend_nxt  = PEND_NONE;
          end else begin
            w_idx_nxt = w_p[5:0];
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_first_nxt = 1'b0;
          if (r_last) begin
            w_first_nxt  = 1'b1;
            w_bitcnt_nxt = '0;
            w_idx_nxt    = '0;
            w_buf_nxt    = '0;
            w_last_nxt   = 1'b0;
            w_state_nxt  = FILL;
          end else if (r_pend != PEND_NONE) begin
            w_state_nxt = EXTRA;
          end else begin
            w_idx_nxt   = '0;
            w_buf_nxt   = '0;
            w_state_nxt = FILL;
          end
        end
      end
      EXTRA: begin
        w_buf_nxt        = '0;
        w_buf_nxt[56:63] = 64'(r_bitcnt);
        if (r_pend == PEND_80) w_buf_nxt[0] = 8'h80;
        w_last_nxt  = 1'b1;
        w_pend_nxt  = PEND_NONE;
        w_state_nxt = EMIT;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FILL;
      r_pend   <= PEND_NONE;
      r_buf    <= '0;
      r_idx    <= '0;
      r_bitcnt <= '0;
      r_first  <= 1'b1;
      r_last   <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= w_pend_nxt;
      r_buf    <= w_buf_nxt;
      r_idx    <= w_idx_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_first  <= w_first_nxt;
      r_last   <= w_last_nxt;
      r_live   <= 1'b1;
    end
  end

  // r_live holds in_ready low for the first cycle out of reset.
  assign in_ready  = r_live & (r_state == FILL);
  assign out_valid = (r_state == EMIT);
  assign out_block = r_buf;
  assign out_first = r_first & out_valid;
  assign out_last  = r_last & out_valid;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: fixed vectors, a reset-abort sequence and random messages
// compared against a queue-based padding model.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;

  sha256_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_last   (in_last),
`ifdef SHA256_PADDER_EMPTY_EN
    .in_empty  (1'b0),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    int           gap;
  } blk_t;
  typedef struct {
    int          len;
    int          pat;
    int          stall;
    int          exp_n;
    logic [63:0] exp_len;
    int          m_blk;
    int          m_byte;
    bit          extra;
  } vec_t;

  blk_t got_q[$];
  blk_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   sink_stall = 0;
  int   prev_hs = -1;
  int   excl_viol = 0;
  int   stab_viol = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [511:0] d, input int k);
    return d[511-8*k -: 8];
  endfunction

  // Reference: append 0x80, zero-pad to 56 mod 64, append 64-bit length, cut into blocks.
  function automatic void ref_pad(input byte_q_t msg);
    byte_q_t     p;
    logic [63:0] bits;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      blk_t e;
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data = {e.data[503:0], p[64*b+j]};
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      e.gap   = 0;
      exp_q.push_back(e);
    end
  endfunction

  // Consumer: holds out_ready low sink_stall cycles per block, watches stability and exclusivity.
  initial begin
    int           wcnt;
    int           rise;
    logic [513:0] held;
    blk_t         b;
    wcnt = 0;
    rise = 0;
    held = '0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        out_ready = 1'b0;
        wcnt = 0;
      end else begin
        if (in_ready && out_valid) excl_viol++;
        if (out_valid) begin
          if (wcnt == 0) begin
            held = {out_block, out_first, out_last};
            rise = cyc;
          end else if ({out_block, out_first, out_last} !== held) begin
            stab_viol++;
          end
          if (wcnt >= sink_stall) begin
            out_ready = 1'b1;
            b.data  = held[513:2];
            b.first = held[1];
            b.last  = held[0];
            b.gap   = (prev_hs < 0) ? -1 : rise - prev_hs;
            got_q.push_back(b);
            prev_hs = cyc;
            wcnt = 0;
          end else begin
            out_ready = 1'b0;
            wcnt++;
          end
        end else begin
          out_ready = 1'b0;
          wcnt = 0;
        end
      end
    end
  end

  task automatic send_msg(input byte_q_t msg, input bit do_last, input int gap_pct);
    for (int i = 0; i < msg.size(); i++) begin
      int idle;
      int t;
      bit acc;
      idle = 0;
      while (idle < 8 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        idle++;
      end
      in_valid = 1'b1;
      in_byte  = msg[i];
      in_last  = do_last && (i == msg.size() - 1);
      acc = 1'b0;
      t = 0;
      while (!acc && t < 400) begin
        acc = in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        chk("in_accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      if (in_last || ((i + 1) % 64 == 0)) chk("out_valid_latency", out_valid, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input string name, input byte_q_t msg, input int stall, input int gap_pct);
    got_q.delete();
    excl_viol = 0;
    stab_viol = 0;
    sink_stall = stall;
    ref_pad(msg);
    send_msg(msg, 1'b1, gap_pct);
    wait_blocks(exp_q.size());
    chk({name, " nblocks"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s blk%0d data", name, i), got_q[i].data, exp_q[i].data);
        chk($sformatf("%s blk%0d first", name, i), got_q[i].first, exp_q[i].first);
        chk($sformatf("%s blk%0d last", name, i), got_q[i].last, exp_q[i].last);
      end
    end
    chk({name, " ready_during_emit"}, excl_viol, 0);
    chk({name, " block_stable"}, stab_viol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[5];
    byte_q_t      m;
    logic [511:0] abc_blk;
    int           nb;

    abc_blk = {32'h61626380, 416'h0, 64'h18};
    vecs[0] = vec_t'{3,   0, 0,  1, 64'h18,  0, 3,  1'b0};
    vecs[1] = vec_t'{55,  1, 0,  1, 64'h1B8, 0, 55, 1'b0};
    vecs[2] = vec_t'{56,  1, 0,  2, 64'h1C0, 0, 56, 1'b1};
    vecs[3] = vec_t'{64,  1, 0,  2, 64'h200, 1, 0,  1'b1};
    vecs[4] = vec_t'{130, 1, 10, 3, 64'h410, 2, 2,  1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_byte = 8'h00;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_first", out_first, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_block", out_block, 0);
    rst = 1'b0;
    #1;
    chk("in_ready before first edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready after reset", in_ready, 1);

    for (int vi = 0; vi < 5; vi++) begin
      m = {};
      for (int j = 0; j < vecs[vi].len; j++)
        m.push_back((vecs[vi].pat == 0) ? 8'(8'h61 + j) : 8'h41);
      run_msg($sformatf("vec%0d", vi), m, vecs[vi].stall, 0);
      nb = got_q.size();
      chk($sformatf("vec%0d nblocks_const", vi), nb, vecs[vi].exp_n);
      if (nb == vecs[vi].exp_n) begin
        chk($sformatf("vec%0d len_field", vi), got_q[nb-1].data[63:0], vecs[vi].exp_len);
        chk($sformatf("vec%0d pad80", vi),
            byte_at(got_q[vecs[vi].m_blk].data, vecs[vi].m_byte), 8'h80);
        chk($sformatf("vec%0d first_tag", vi), got_q[0].first, 1);
        chk($sformatf("vec%0d last_tag", vi), got_q[nb-1].last, 1);
        if (nb > 1) begin
          chk($sformatf("vec%0d blk0_not_last", vi), got_q[0].last, 0);
          chk($sformatf("vec%0d final_not_first", vi), got_q[nb-1].first, 0);
        end
        if (vecs[vi].extra) chk($sformatf("vec%0d extra_gap", vi), got_q[nb-1].gap, 2);
        if (vecs[vi].pat == 0) chk("abc block", got_q[0].data, abc_blk);
      end
    end

    // Abort message A after 20 bytes with reset, then send "abc".
    got_q.delete();
    m = {};
    for (int j = 0; j < 20; j++) m.push_back(8'h5A);
    sink_stall = 0;
    send_msg(m, 1'b0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid-reset out_valid", out_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort no_blocks", got_q.size(), 0);
    m = {};
    m.push_back(8'h61);
    m.push_back(8'h62);
    m.push_back(8'h63);
    run_msg("after_reset", m, 0, 0);
    if (got_q.size() == 1) begin
      chk("after_reset first", got_q[0].first, 1);
      chk("after_reset block", got_q[0].data, abc_blk);
    end

    for (int r = 0; r < 30; r++) begin
      int len;
      m = {};
      len = (r % 5 == 0) ? $urandom_range(54, 66) : $urandom_range(1, 200);
      for (int j = 0; j < len; j++) m.push_back(8'($urandom));
      run_msg($sformatf("rand%0d len%0d", r, len), m, $urandom_range(0, 3), 30);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
